// File: rtl/seven_seg_rx.sv
// -----------------------------------------------------------------------------
// seven_seg_rx
//
// Receive side of a two-digit multiplexed seven-segment link. It watches the
// driver's time-multiplexed segment bus and its one-cycle digit strobe. It
// rebuilds the high/low digit pair and decodes each pattern back to a hex
// nibble. It flags any pair that contains a pattern it cannot decode.
//
// Optional feature (macro SEVEN_SEG_RX_TIMEOUT_EN):
//   defined   - a strobe watchdog is built. link_lost rises after TIMEOUT
//               strobe-free cycles, and the pair assembly is resynchronised
//               to expect a high digit.
//   undefined - no watchdog. link_lost is tied to 0. TIMEOUT/CBITS are unused.
//
// Parameters:
//   TIMEOUT      strobe-free cycles before link_lost asserts
//   CBITS        watchdog counter width (TIMEOUT < 2**CBITS)
// Ports:
//   clk          clock, all state updates on posedge
//   rst          asynchronous, active-high reset
//   segment_in   segment pattern, bit0=a .. bit6=g, 1 = lit (valid with sig_in)
//   sig_in       digit strobe, one cycle per digit slot
//   digit_hi     last decoded high digit
//   digit_lo     last decoded low digit
//   pair_valid   one-cycle pulse when a new pair is published
//   decode_err   one-cycle pulse when a completed pair had a bad pattern
//   link_lost    strobe watchdog expired (level)
//   digit_phase  0 = expecting high digit, 1 = expecting low digit
// -----------------------------------------------------------------------------
module seven_seg_rx #(
   parameter int unsigned TIMEOUT = 2047,
   parameter int unsigned CBITS   = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] segment_in,
   input  logic       sig_in,
   output logic [3:0] digit_hi,
   output logic [3:0] digit_lo,
   output logic       pair_valid,
   output logic       decode_err,
   output logic       link_lost,
   output logic       digit_phase
);

   typedef enum logic {
      PH_HI = 1'b0,
      PH_LO = 1'b1
   } phase_e;

   typedef struct packed {
      logic       ok;
      logic [3:0] nib;
   } dec_t;

   // Reject an impossible watchdog configuration when the design is elaborated.
   if (TIMEOUT >= (64'd1 << CBITS)) begin : g_bad_cfg
      $error("seven_seg_rx: TIMEOUT must be below 2**CBITS");
   end

   function automatic dec_t decode_seg(input logic [6:0] pat);
      dec_t r;
      r.ok = 1'b1;
      case (pat)
         7'h3F: r.nib = 4'h0;
         7'h06: r.nib = 4'h1;
         7'h5B: r.nib = 4'h2;
         7'h4F: r.nib = 4'h3;
         7'h66: r.nib = 4'h4;
         7'h6D: r.nib = 4'h5;
         7'h7D: r.nib = 4'h6;
         7'h07: r.nib = 4'h7;
         7'h7F: r.nib = 4'h8;
         7'h6F: r.nib = 4'h9;
         7'h77: r.nib = 4'hA;
         7'h7C: r.nib = 4'hB;
         7'h39: r.nib = 4'hC;
         7'h5E: r.nib = 4'hD;
         7'h79: r.nib = 4'hE;
         7'h71: r.nib = 4'hF;
         default: begin
            // Blank and every other pattern are not digits.
            r.ok  = 1'b0;
            r.nib = 4'h0;
         end
      endcase
      return r;
   endfunction

   phase_e     phase_q, phase_d;
   logic [6:0] held_q, held_d;
   logic [3:0] digit_hi_q, digit_hi_d;
   logic [3:0] digit_lo_q, digit_lo_d;
   logic       pair_valid_q, pair_valid_d;
   logic       decode_err_q, decode_err_d;
   dec_t       dec_hi, dec_lo;

`ifdef SEVEN_SEG_RX_TIMEOUT_EN
   localparam logic [CBITS-1:0] TIMEOUT_C = CBITS'(TIMEOUT);

   logic [CBITS-1:0] wd_q, wd_d;
   logic             link_lost_q, link_lost_d;
`endif

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path
      // through this block can leave a value unassigned and infer a latch.
      phase_d      = phase_q;
      held_d       = held_q;
      digit_hi_d   = digit_hi_q;
      digit_lo_d   = digit_lo_q;
      pair_valid_d = 1'b0;
      decode_err_d = 1'b0;
      dec_hi       = decode_seg(held_q);
      dec_lo       = decode_seg(segment_in);
`ifdef SEVEN_SEG_RX_TIMEOUT_EN
      wd_d         = wd_q;
      link_lost_d  = link_lost_q;
`endif

      if (sig_in) begin
         case (phase_q)
            PH_HI: begin
               held_d  = segment_in;
               phase_d = PH_LO;
            end
            default: begin
               phase_d = PH_HI;
               if (dec_hi.ok && dec_lo.ok) begin
                  digit_hi_d   = dec_hi.nib;
                  digit_lo_d   = dec_lo.nib;
                  pair_valid_d = 1'b1;
               end else begin
                  decode_err_d = 1'b1;
               end
            end
         endcase
`ifdef SEVEN_SEG_RX_TIMEOUT_EN
         // A strobe always wins over an expiring watchdog.
         wd_d        = '0;
         link_lost_d = 1'b0;
      end else if (wd_q != TIMEOUT_C) begin
         wd_d = wd_q + CBITS'(1);
         // Expiry happens on the edge that reaches TIMEOUT. Drop any
         // half-received pair so the next strobe is taken as a high digit.
         if (wd_d == TIMEOUT_C) begin
            link_lost_d = 1'b1;
            phase_d     = PH_HI;
            held_d      = '0;
         end
      end
`else
      end
`endif
   end

   // NOTE: state registers use non-blocking assignments so that every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q      <= PH_HI;
         held_q       <= '0;
         digit_hi_q   <= '0;
         digit_lo_q   <= '0;
         pair_valid_q <= 1'b0;
         decode_err_q <= 1'b0;
`ifdef SEVEN_SEG_RX_TIMEOUT_EN
         wd_q         <= '0;
         link_lost_q  <= 1'b0;
`endif
      end else begin
         phase_q      <= phase_d;
         held_q       <= held_d;
         digit_hi_q   <= digit_hi_d;
         digit_lo_q   <= digit_lo_d;
         pair_valid_q <= pair_valid_d;
         decode_err_q <= decode_err_d;
`ifdef SEVEN_SEG_RX_TIMEOUT_EN
         wd_q         <= wd_d;
         link_lost_q  <= link_lost_d;
`endif
      end
   end

   assign digit_hi    = digit_hi_q;
   assign digit_lo    = digit_lo_q;
   assign pair_valid  = pair_valid_q;
   assign decode_err  = decode_err_q;
   assign digit_phase = (phase_q == PH_LO);
`ifdef SEVEN_SEG_RX_TIMEOUT_EN
   assign link_lost   = link_lost_q;
`else
   assign link_lost   = 1'b0;
`endif

endmodule
